// File: rtl/cond_move_unit.sv
// EX-stage conditional-move unit: MOVZ/MOVN/MOVE decision on rt with registered GPR write outputs,
// an optional split zero-detect stage, stall/flush handling and a saturating suppressed-write counter.
module cond_move_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int PIPE   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              in_valid,
  input  logic [1:0]        in_mode,
  input  logic [WIDTH-1:0]  in_rt,
  input  logic [WIDTH-1:0]  in_rs,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              cnt_clr,
  output logic              out_valid,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_zero,
  output logic [CNT_W-1:0]  supp_cnt
);

  localparam int         NB     = WIDTH / 8;
  localparam logic [1:0] M_MOVZ = 2'b00;
  localparam logic [1:0] M_MOVN = 2'b01;
  localparam logic [1:0] M_MOVE = 2'b10;

  logic [NB-1:0] byte_nz;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bnz
      assign byte_nz[gi] = |in_rt[gi*8 +: 8];
    end
  endgenerate

  // Operand view presented to the final (decision) stage.
  logic              f_valid;
  logic [1:0]        f_mode;
  logic              f_zero;
  logic [WIDTH-1:0]  f_rs;
  logic [ADDR_W-1:0] f_addr;

  generate
    if (PIPE == 2) begin : g_pipe2
      logic              s1_valid_q, s1_valid_d;
      logic [1:0]        s1_mode_q, s1_mode_d;
      logic [NB-1:0]     s1_nz_q, s1_nz_d;
      logic [WIDTH-1:0]  s1_rs_q, s1_rs_d;
      logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;

      always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_nz_d    = s1_nz_q;
        s1_rs_d    = s1_rs_q;
        s1_addr_d  = s1_addr_q;
        if (flush_in) begin
          s1_valid_d = 1'b0;
        end else if (!stall_in) begin
          s1_valid_d = in_valid;
          s1_mode_d  = in_mode;
          s1_nz_d    = byte_nz;
          s1_rs_d    = in_rs;
          s1_addr_d  = in_addr;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_valid_q <= 1'b0;
          s1_mode_q  <= '0;
          s1_nz_q    <= '0;
          s1_rs_q    <= '0;
          s1_addr_q  <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_mode_q  <= s1_mode_d;
          s1_nz_q    <= s1_nz_d;
          s1_rs_q    <= s1_rs_d;
          s1_addr_q  <= s1_addr_d;
        end
      end

      assign f_valid = s1_valid_q;
      assign f_mode  = s1_mode_q;
      assign f_zero  = ~|s1_nz_q;
      assign f_rs    = s1_rs_q;
      assign f_addr  = s1_addr_q;
    end else begin : g_pipe1
      assign f_valid = in_valid;
      assign f_mode  = in_mode;
      assign f_zero  = ~|byte_nz;
      assign f_rs    = in_rs;
      assign f_addr  = in_addr;
    end
  endgenerate

  logic f_cond;

  always_comb begin
    f_cond = 1'b0;
    case (f_mode)
      M_MOVZ:  f_cond = f_zero;
      M_MOVN:  f_cond = ~f_zero;
      M_MOVE:  f_cond = 1'b1;
      default: f_cond = 1'b0;
    endcase
  end

  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic              zero_q, zero_d;
  logic              supp_q, supp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Flag bits are qualified by valid on load so they are never set while the stage is empty.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    zero_d  = zero_q;
    supp_d  = supp_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (flush_in) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      zero_d  = 1'b0;
      supp_d  = 1'b0;
    end else if (!stall_in) begin
      valid_d = f_valid;
      we_d    = f_valid & f_cond & (f_addr != '0);
      zero_d  = f_valid & f_zero;
      supp_d  = f_valid & ((f_mode == M_MOVZ) | (f_mode == M_MOVN)) & ~f_cond;
      addr_d  = f_addr;
      data_d  = f_rs;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (supp_q && !stall_in && !flush_in && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      zero_q  <= 1'b0;
      supp_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      zero_q  <= zero_d;
      supp_q  <= supp_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_we    = we_q;
  assign out_zero  = zero_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign supp_cnt  = cnt_q;

endmodule
